// File: rtl/dma_csr_pkg.sv
// Purpose: shared register map, bit positions, response codes and helpers for the DMA CSR block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_csr_pkg;

  // Byte offsets of the five mapped registers (address bits [4:0]).
  localparam logic [4:0] CSR_CTRL   = 5'h00;
  localparam logic [4:0] CSR_STATUS = 5'h04;
  localparam logic [4:0] CSR_SRC    = 5'h08;
  localparam logic [4:0] CSR_DST    = 5'h0C;
  localparam logic [4:0] CSR_LEN    = 5'h10;

  // Bit positions inside CTRL and STATUS.
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ERR      = 2;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // One captured write-data beat.
  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  strb;
  } wbeat_t;

  // Byte-lane merge of new data into an existing register value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_axil_csr.sv
// Purpose: AXI-Lite slave CSR file for the DMA engine (CTRL, STATUS, SRC, DST, LEN) plus level irq.
// Latency: write commits on the edge of the later AW/W handshake (BVALID next cycle); read data one cycle after AR.
// Backpressure: AW/W stall while their holding register is full or BVALID is pending; AR stalls while RVALID is pending.
// Ports: ACLK/ARESETN clock and async active-low reset; AW/W/B/AR/R AXI-Lite slave channels;
//        src_addr_o/dst_addr_o/len_o/start_o controls to the engine; busy_i/done_i/err_i status in; irq_o to host.
module dma_axil_csr
  import dma_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [31:0]             src_addr_o,
  output logic [31:0]             dst_addr_o,
  output logic [31:0]             len_o,
  output logic                    start_o,
  input  logic                    busy_i,
  input  logic                    done_i,
  input  logic                    err_i,
  output logic                    irq_o
);

  // Write-side state
  logic        aw_full_q, w_full_q, bvalid_q, start_q;
  logic [4:0]  aw_addr_q;
  wbeat_t      w_q;
  resp_t       bresp_q;
  logic        irq_en_q, done_q, err_q;
  logic [31:0] src_q, dst_q, len_q;
  // Read-side state
  logic        rvalid_q;
  logic [31:0] rdata_q;
  resp_t       rresp_q;

  // Next-state values
  logic        irq_en_d, done_d, err_d, start_d, clr_done, clr_err;
  logic [31:0] src_d, dst_d, len_d, rdata_d;
  resp_t       bresp_d, rresp_d;

  logic        aw_hs, w_hs, ar_hs, wr_commit;
  logic [4:0]  wr_addr;
  wbeat_t      w_in, wr_beat;

  // Upper address bits are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:5], ARADDR[ADDR_WIDTH-1:5]};

  assign AWREADY = !aw_full_q && !bvalid_q;
  assign WREADY  = !w_full_q && !bvalid_q;
  assign ARREADY = !rvalid_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // Commit on the handshake edge itself: each half comes either from its
  // holding register or straight off the bus when it arrives this cycle.
  assign w_in      = {WDATA, WSTRB};
  assign wr_addr   = aw_full_q ? aw_addr_q : AWADDR[4:0];
  assign wr_beat   = w_full_q ? w_q : w_in;
  assign wr_commit = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;

  always_comb begin
    irq_en_d = irq_en_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    start_d  = 1'b0;
    bresp_d  = RESP_OKAY;
    clr_done = 1'b0;
    clr_err  = 1'b0;
    if (wr_commit) begin
      // Full 5-bit compare: misaligned and unmapped offsets both fall to default.
      case (wr_addr)
        CSR_CTRL: begin
          if (wr_beat.strb[0]) begin
            irq_en_d = wr_beat.dat[CTRL_IRQ_EN];
            if (wr_beat.dat[CTRL_START]) begin
              if (busy_i) bresp_d = RESP_SLVERR;
              else        start_d = 1'b1;
            end
          end
        end
        CSR_STATUS: begin
          clr_done = wr_beat.strb[0] && wr_beat.dat[ST_DONE];
          clr_err  = wr_beat.strb[0] && wr_beat.dat[ST_ERR];
        end
        CSR_SRC: src_d = apply_strb(src_q, wr_beat.dat, wr_beat.strb);
        CSR_DST: dst_d = apply_strb(dst_q, wr_beat.dat, wr_beat.strb);
        CSR_LEN: len_d = apply_strb(len_q, wr_beat.dat, wr_beat.strb);
        default: bresp_d = RESP_SLVERR;
      endcase
    end
    // Engine events take priority over a same-cycle W1C.
    done_d = done_i || (done_q && !clr_done);
    err_d  = err_i  || (err_q  && !clr_err);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_q       <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
    end else begin
      start_q  <= start_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= AWADDR[4:0];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_q      <= w_in;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (bvalid_q && BREADY) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  // Read mux works from current register state, so a read colliding with a
  // write commit returns the pre-write value.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (ARADDR[4:0])
      CSR_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
      CSR_STATUS: begin
        rdata_d[ST_BUSY] = busy_i;
        rdata_d[ST_DONE] = done_q;
        rdata_d[ST_ERR]  = err_q;
      end
      CSR_SRC:    rdata_d = src_q;
      CSR_DST:    rdata_d = dst_q;
      CSR_LEN:    rdata_d = len_q;
      default:    rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign len_o      = len_q;
  assign start_o    = start_q;
  assign irq_o      = irq_en_q && (done_q || err_q);

endmodule

// File: tb/tb_dma_axil_csr.sv
// Purpose: directed self-checking bench for dma_axil_csr against a register-map level model.
// Latency: n/a.
// Backpressure: exercises AW/W skew, held BREADY and held RREADY.
module tb_dma_axil_csr;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] src_addr_o, dst_addr_o, len_o;
  logic        start_o, busy_i, done_i, err_i, irq_o;

  always #5 ACLK = ~ACLK;

  dma_axil_csr #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .err_i(err_i),
    .irq_o(irq_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  bit chk_en = 0;

  // Register-map model
  logic [31:0] m_src = 0, m_dst = 0, m_len = 0;
  logic        m_irq_en = 0, m_done = 0, m_err = 0;
  logic        m_bvalid = 0, m_rvalid = 0, exp_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_src = 0; m_dst = 0; m_len = 0; m_irq_en = 0; m_done = 0; m_err = 0;
    m_bvalid = 0; m_rvalid = 0; exp_start = 0;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    r = 2'b00;
    case (a)
      32'h00: if (s[0]) begin
        m_irq_en = d[1];
        if (d[0]) begin
          if (busy_i) r = 2'b10;
          else        exp_start = 1;
        end
      end
      32'h04: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      32'h08: m_src = merge(m_src, d, s);
      32'h0C: m_dst = merge(m_dst, d, s);
      32'h10: m_len = merge(m_len, d, s);
      default: r = 2'b10;
    endcase
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    d = 0;
    case (a)
      32'h00: d = {30'd0, m_irq_en, 1'b0};
      32'h04: d = {29'd0, m_err, m_done, busy_i};
      32'h08: d = m_src;
      32'h0C: d = m_dst;
      32'h10: d = m_len;
      default: r = 2'b10;
    endcase
  endtask

  // Cycle-by-cycle compare of the always-meaningful outputs.
  always @(negedge ACLK) begin
    if (chk_en) begin
      check("src_addr_o", src_addr_o, m_src);
      check("dst_addr_o", dst_addr_o, m_dst);
      check("len_o", len_o, m_len);
      check("irq_o", {31'd0, irq_o}, {31'd0, m_irq_en & (m_done | m_err)});
      check("start_o", {31'd0, start_o}, {31'd0, exp_start});
      check("BVALID", {31'd0, BVALID}, {31'd0, m_bvalid});
      check("RVALID", {31'd0, RVALID}, {31'd0, m_rvalid});
      if (start_o) start_cnt++;
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W. Called and returns at posedge+1.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bhold, output logic [1:0] resp, output int edges);
    bit aw_done, w_done, hs_aw, hs_w, ev_d, ev_e;
    logic [1:0] er;
    aw_done = 0; w_done = 0; er = 2'b00; edges = 0;
    AWADDR = a; WDATA = d; WSTRB = s; BREADY = 0;
    WVALID  = (lead >= 0);
    AWVALID = (lead <= 0);
    while (!(aw_done && w_done) && edges < 30) begin
      hs_aw = AWVALID & AWREADY;
      hs_w  = WVALID & WREADY;
      ev_d  = done_i;
      ev_e  = err_i;
      @(posedge ACLK); #1;
      edges++;
      done_i = 0; err_i = 0;
      if (hs_aw) begin aw_done = 1; AWVALID = 0; end
      if (hs_w)  begin w_done = 1;  WVALID = 0;  end
      if (lead > 0 && edges == lead && !aw_done) AWVALID = 1;
      if (lead < 0 && edges == -lead && !w_done) WVALID = 1;
      if (aw_done && w_done) m_write(a, d, s, er);
      if (ev_d) m_done = 1;
      if (ev_e) m_err = 1;
      if (aw_done && w_done) m_bvalid = 1;
    end
    if (!(aw_done && w_done)) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout: addr 0x%08h got no handshake, required one within 30 cycles", a);
      AWVALID = 0; WVALID = 0; resp = 2'b11;
      return;
    end
    check("BRESP", {30'd0, BRESP}, {30'd0, er});
    resp = BRESP;
    for (int i = 0; i < bhold; i++) begin
      @(posedge ACLK); #1;
      exp_start = 0;
      check("AWREADY_bhold", {31'd0, AWREADY}, 32'd0);
      check("WREADY_bhold", {31'd0, WREADY}, 32'd0);
    end
    BREADY = 1;
    @(posedge ACLK); #1;
    exp_start = 0; BREADY = 0; m_bvalid = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int rhold, output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] ed;
    logic [1:0]  er;
    bit hs;
    int n;
    hs = 0; n = 0; ed = 0; er = 0;
    ARADDR = a; ARVALID = 1; RREADY = 0;
    while (!hs && n < 30) begin
      hs = ARREADY;
      m_read(a, ed, er);
      @(posedge ACLK); #1;
      n++;
    end
    ARVALID = 0;
    if (!hs) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: addr 0x%08h got no AR handshake, required one within 30 cycles", a);
      data = 0; resp = 2'b11;
      return;
    end
    m_rvalid = 1;
    check("RDATA", RDATA, ed);
    check("RRESP", {30'd0, RRESP}, {30'd0, er});
    data = RDATA; resp = RRESP;
    for (int i = 0; i < rhold; i++) begin
      @(posedge ACLK); #1;
      check("RDATA_held", RDATA, ed);
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0; m_rvalid = 0;
  endtask

  task automatic pulse_evt(input bit d, input bit e);
    done_i = d; err_i = e;
    @(posedge ACLK); #1;
    done_i = 0; err_i = 0;
    if (d) m_done = 1;
    if (e) m_err = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr, br2;
    logic [31:0] rd;
    int          ed;
    ARESETN = 0; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0; busy_i = 0; done_i = 0; err_i = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_BVALID", {31'd0, BVALID}, 0);
    check("rst_RVALID", {31'd0, RVALID}, 0);
    check("rst_start", {31'd0, start_o}, 0);
    check("rst_irq", {31'd0, irq_o}, 0);
    check("rst_BRESP", {30'd0, BRESP}, 0);
    check("rst_RRESP", {30'd0, RRESP}, 0);
    check("rst_RDATA", RDATA, 0);
    check("rst_src", src_addr_o, 0);
    check("rst_len", len_o, 0);
    @(posedge ACLK); #1;
    ARESETN = 1;
    check("rst_AWREADY", {31'd0, AWREADY}, 1);
    check("rst_WREADY", {31'd0, WREADY}, 1);
    check("rst_ARREADY", {31'd0, ARREADY}, 1);
    chk_en = 1;

    // Full write and readback
    axi_write(32'h08, 32'hDEADBEEF, 4'b1111, 0, 0, br, ed);
    check("src_full_bresp", {30'd0, br}, 0);
    check("src_full_edges", ed, 1);
    axi_read(32'h08, 2, rd, rr);
    check("src_full_rd", rd, 32'hDEADBEEF);
    check("src_full_rresp", {30'd0, rr}, 0);

    // Byte-lane writes
    axi_write(32'h08, 32'h0000AB00, 4'b0010, 0, 0, br, ed);
    axi_read(32'h08, 0, rd, rr);
    check("src_strb_rd", rd, 32'hDEADABEF);
    axi_write(32'h0C, 32'h12345678, 4'b1001, 0, 0, br, ed);
    axi_read(32'h0C, 0, rd, rr);
    check("dst_strb_rd", rd, 32'h12000078);

    // W three cycles ahead of AW
    axi_write(32'h10, 32'h00000100, 4'b1111, 3, 0, br, ed);
    check("len_wlead_edges", ed, 4);
    axi_read(32'h10, 0, rd, rr);
    check("len_wlead_rd", rd, 32'h100);

    // Start, done, irq, W1C
    axi_write(32'h00, 32'h3, 4'b1111, 0, 0, br, ed);
    check("start_bresp", {30'd0, br}, 0);
    check("start_count", start_cnt, 1);
    axi_read(32'h00, 0, rd, rr);
    check("ctrl_rd", rd, 32'h2);
    pulse_evt(1, 0);
    check("irq_after_done", {31'd0, irq_o}, 1);
    axi_read(32'h04, 0, rd, rr);
    check("status_done_rd", rd, 32'h2);
    axi_write(32'h04, 32'h2, 4'b0000, 0, 0, br, ed);
    check("irq_w1c_nostrb", {31'd0, irq_o}, 1);
    axi_write(32'h04, 32'h2, 4'b0001, 0, 0, br, ed);
    check("irq_w1c", {31'd0, irq_o}, 0);

    // START while busy
    busy_i = 1;
    axi_write(32'h00, 32'h1, 4'b1111, 0, 0, br, ed);
    check("busy_start_bresp", {30'd0, br}, 2'b10);
    check("busy_start_count", start_cnt, 1);
    axi_read(32'h04, 0, rd, rr);
    check("status_busy_rd", rd, 32'h1);
    axi_read(32'h00, 0, rd, rr);
    check("ctrl_irqen_cleared", rd, 32'h0);
    busy_i = 0;

    // Unmapped / misaligned
    axi_read(32'h18, 0, rd, rr);
    check("unmapped_rd", rd, 0);
    check("unmapped_rresp", {30'd0, rr}, 2'b10);
    axi_read(32'h0A, 0, rd, rr);
    check("misaligned_rresp", {30'd0, rr}, 2'b10);
    axi_write(32'h14, 32'hFFFFFFFF, 4'b1111, 0, 0, br, ed);
    check("unmapped_bresp", {30'd0, br}, 2'b10);
    axi_write(32'h09, 32'hFFFFFFFF, 4'b1111, 0, 0, br, ed);
    check("misaligned_bresp", {30'd0, br}, 2'b10);
    check("misaligned_src_kept", src_addr_o, 32'hDEADABEF);

    // Error event, set beats same-cycle W1C
    axi_write(32'h00, 32'h2, 4'b1111, 0, 0, br, ed);
    pulse_evt(0, 1);
    check("irq_after_err", {31'd0, irq_o}, 1);
    err_i = 1;
    axi_write(32'h04, 32'h4, 4'b0001, 0, 0, br, ed);
    axi_read(32'h04, 0, rd, rr);
    check("set_wins_rd", rd, 32'h4);
    axi_write(32'h04, 32'h6, 4'b0001, 0, 0, br, ed);
    axi_read(32'h04, 0, rd, rr);
    check("status_cleared_rd", rd, 32'h0);
    check("irq_cleared", {31'd0, irq_o}, 0);

    // Read colliding with a write commit sees the old value
    fork
      axi_write(32'h08, 32'h11111111, 4'b1111, 0, 0, br2, ed);
      axi_read(32'h08, 0, rd, rr);
    join
    check("collide_old_rd", rd, 32'hDEADABEF);
    axi_read(32'h08, 0, rd, rr);
    check("collide_new_rd", rd, 32'h11111111);

    // BREADY held low
    axi_write(32'h0C, 32'hCAFEF00D, 4'b1111, 0, 5, br, ed);
    axi_read(32'h0C, 0, rd, rr);
    check("dst_bhold_rd", rd, 32'hCAFEF00D);

    // Reset with a W beat parked in the holding register
    WDATA = 32'h0BAD0BAD; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); #1;
    WVALID = 0;
    chk_en = 0;
    ARESETN = 0;
    #2;
    check("midrst_src", src_addr_o, 0);
    check("midrst_WREADY", {31'd0, WREADY}, 1);
    m_reset();
    @(posedge ACLK); #1;
    ARESETN = 1;
    chk_en = 1;
    axi_write(32'h10, 32'h55, 4'b1111, -2, 0, br, ed);
    check("midrst_awlead_edges", ed, 3);
    axi_read(32'h10, 0, rd, rr);
    check("midrst_len_rd", rd, 32'h55);

    repeat (2) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
